cmd_rr_arbiter: RTL and testbench
=================================

Name: cmd_rr_arbiter

Overview:
- Shares one downstream dut slave command port (cmd/adr/data, no backpressure) between NUM_REQ requesters.
- Uses round-robin arbitration with burst locking and a forced burst cut after MAX_BURST beats.
- Sits in front of the first dut in a chain, driving the same signals a bench or upstream master drives into dut_if.
- Output is registered; cmd==0 on the output means idle/no-op.

Parameters:
- NUM_REQ, 3: number of requesters (1..8).
- CMD_W, 2: command width.
- ADR_W, 4: address width.
- DATA_W, 8: data width.
- MAX_BURST, 4: maximum beats per grant before forced release (>=1).

Ports:
Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  beat is last of requester's burst.
- req_cmd  in  NUM_REQ*CMD_W  packed commands, requester i at bits [i*CMD_W +: CMD_W].
- req_adr  in  NUM_REQ*ADR_W  packed addresses.
- req_data  in  NUM_REQ*DATA_W  packed data.
- req_ready  out  NUM_REQ  combinational accept; transfer = valid & ready.
- out_cmd  out  CMD_W  registered command to dut slave.
- out_adr  out  ADR_W  registered address.
- out_data  out  DATA_W  registered data.
- grant_id  out  clog2(NUM_REQ) (min 1)  owner of the beat currently on out_*.
- busy  out  1  high while in LOCKED.
- burst_cut  out  1  one-cycle registered pulse when a burst is force-released.

Behaviour:
- Reset values:
  - out_cmd=0, out_adr=0, out_data=0, grant_id=0, busy=0, burst_cut=0.
  - State IDLE, rr_ptr=0, beat_cnt=0, owner=0.
  - req_ready=0 during any cycle with rst=1.
- States:
  - IDLE: winner = first i with req_valid[i], scanning from rr_ptr upward with wrap. req_ready[winner]=1, all others 0. No valid requester -> all ready 0.
  - LOCKED: only req_ready[owner]=req_valid[owner]; all others 0.
- Transitions:
  - IDLE, winner w transfers, req_last[w]=1 or MAX_BURST==1 -> stay IDLE, rr_ptr=(w+1) mod NUM_REQ.
  - IDLE, winner w transfers, req_last[w]=0, MAX_BURST>1 -> LOCKED, owner=w, beat_cnt=1.
  - LOCKED, owner transfers with req_last=1 -> IDLE, rr_ptr=owner+1 mod NUM_REQ, beat_cnt=0.
  - LOCKED, owner transfers, req_last=0, beat_cnt+1==MAX_BURST -> IDLE, rr_ptr=owner+1, burst_cut=1 next cycle.
  - LOCKED, owner transfers, otherwise -> beat_cnt+1.
  - LOCKED, owner not valid -> hold state; bubble (out_cmd=0) that cycle.
- Datapath:
  - Latency 1: beat accepted in cycle N appears on out_* in cycle N+1, with grant_id=requester index.
  - Cycles with no transfer: out_cmd=0; out_adr, out_data and grant_id hold previous values.
  - A requester beat carrying cmd==0 is accepted and forwarded unchanged; it counts as a beat.
- Boundary conditions:
  - The release cycle and the next grant never overlap. The cycle after release arbitrates with the updated rr_ptr, so back-to-back single beats from different requesters are possible every cycle.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - NUM_REQ==1: requester 0 is always the winner; rr_ptr stays 0.
  - Reset mid-burst: next cycle IDLE, rr_ptr=0, out_cmd=0. The interrupted burst is abandoned; no ready is given during reset.
  - req_valid dropping mid-burst does not release the lock; only last or the MAX_BURST cut releases it.

Test Plan:
- Reset, then req 0/1/2 all valid every cycle, each beat last=1, cmds 1/2/3 -> out_cmd sequence 1,2,3,1,2,3 from cycle 2 onward; grant_id 0,1,2,0,...
- Req1 burst of 3 beats (adr 3,4,3; last on beat 3) while req0 is valid -> req0 ready stays 0 for the 3 cycles; out shows adr 3,4,3 with grant_id=1; next grant goes to req2 if valid, else req0.
- Req2 burst of 6 beats, no last, MAX_BURST=4 -> 4 beats forwarded, burst_cut=1 one cycle after the 4th is accepted; req0 then wins; req2's beat 5 waits for its next turn.
- Req0 locked, drops valid for 2 cycles mid-burst -> out_cmd=0 for those 2 cycles, busy=1 throughout, req1 ready stays 0.
- rst asserted during beat 2 of a req1 burst -> next cycle out_cmd=0, busy=0; then req1 and req2 both valid -> req0 priority is absent, so req1 wins (rr_ptr=0 scan).
- No requests for 10 cycles after reset -> out_cmd=0, out_adr=0, out_data=0, req_ready=0 throughout.

Source files
------------

// File: rtl/cmd_rr_arbiter.sv
// Purpose : round-robin arbiter sharing one dut slave command port between NUM_REQ requesters.
// Latency : 1 cycle (beat accepted in cycle N is driven on out_* in cycle N+1).
// Backpr. : none downstream; upstream sees a combinational req_ready (transfer = valid & ready).
//
// Ports
//   clk, rst                          clock and synchronous active-high reset
//   req_valid/req_last [NUM_REQ]      per-requester beat valid and end-of-burst marker
//   req_cmd/adr/data                  packed per-requester beat fields, requester i at [i*W +: W]
//   req_ready [NUM_REQ]               combinational accept for each requester
//   out_cmd/adr/data                  registered beat to the dut slave; out_cmd==0 is idle
//   grant_id                          requester that owns the beat currently on out_*
//   busy                              high while a burst holds the lock
//   burst_cut                         one-cycle pulse after a burst is force-released at MAX_BURST
//
// A requester that wins arbitration with req_last low takes a lock and keeps the
// port until it presents req_last or until MAX_BURST beats have been forwarded.
// Dropping req_valid while locked only inserts bubbles; it never releases the lock.

module cmd_rr_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int CMD_W     = 2,
    parameter int ADR_W     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*CMD_W-1:0]    req_cmd,
    input  logic [NUM_REQ*ADR_W-1:0]    req_adr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [CMD_W-1:0]            out_cmd,
    output logic [ADR_W-1:0]            out_adr,
    output logic [DATA_W-1:0]           out_data,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy,
    output logic                        burst_cut
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [ID_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
    logic [ID_W-1:0]    owner_q,     owner_d;
    logic [CMD_W-1:0]   out_cmd_q,   out_cmd_d;
    logic [ADR_W-1:0]   out_adr_q,   out_adr_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic [ID_W-1:0]    grant_id_q,  grant_id_d;
    logic               burst_cut_q, burst_cut_d;

    // ------------------------------------------------------------------
    // Unpack the per-requester fields so the beat mux indexes arrays
    // rather than computed part-selects.
    // ------------------------------------------------------------------
    logic [CMD_W-1:0]   cmd_a  [NUM_REQ];
    logic [ADR_W-1:0]   adr_a  [NUM_REQ];
    logic [DATA_W-1:0]  data_a [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign cmd_a[gi]  = req_cmd [gi*CMD_W  +: CMD_W];
        assign adr_a[gi]  = req_adr [gi*ADR_W  +: ADR_W];
        assign data_a[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // Pointer to the requester after p, wrapping at NUM_REQ-1.
    // With a single requester this always yields 0.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
        if (int'(p) >= NUM_REQ - 1) begin
            return '0;
        end
        return p + ID_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester at or above rr_ptr, with
    // wrap. Only used while IDLE; in LOCKED the owner is fixed.
    // ------------------------------------------------------------------
    logic               found;
    logic [ID_W-1:0]    win;
    int                 idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[ID_W'(idx)]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state, ready generation and output datapath
    // ------------------------------------------------------------------
    logic [ID_W-1:0]    sel;
    logic               xfer;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        owner_d     = owner_q;
        out_cmd_d   = '0;             // bubble unless a beat transfers
        out_adr_d   = out_adr_q;
        out_data_d  = out_data_q;
        grant_id_d  = grant_id_q;
        burst_cut_d = 1'b0;
        req_ready   = '0;
        sel         = owner_q;

        // No ready is ever offered while reset is asserted, so an
        // interrupted burst cannot leak a beat through the reset cycle.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        req_ready[win] = 1'b1;
                        sel            = win;
                    end
                end
                LOCKED: begin
                    req_ready[owner_q] = req_valid[owner_q];
                end
                default: begin
                    req_ready = '0;
                end
            endcase
        end

        xfer = |(req_ready & req_valid);

        if (xfer) begin
            out_cmd_d  = cmd_a[sel];
            out_adr_d  = adr_a[sel];
            out_data_d = data_a[sel];
            grant_id_d = sel;

            case (state_q)
                IDLE: begin
                    // A single-beat grant (or a one-beat burst limit) never
                    // takes the lock; the pointer simply moves past the winner.
                    if (req_last[sel] || (MAX_BURST == 1)) begin
                        rr_ptr_d = next_ptr(sel);
                    end else begin
                        state_d    = LOCKED;
                        owner_d    = sel;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (req_last[sel]) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_ptr(owner_q);
                        beat_cnt_d = '0;
                    end else if (int'(beat_cnt_q) + 1 == MAX_BURST) begin
                        // Burst limit reached without last: release so the
                        // others get a turn. The owner resumes on its next win.
                        state_d     = IDLE;
                        rr_ptr_d    = next_ptr(owner_q);
                        beat_cnt_d  = '0;
                        burst_cut_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            owner_q     <= '0;
            out_cmd_q   <= '0;
            out_adr_q   <= '0;
            out_data_q  <= '0;
            grant_id_q  <= '0;
            burst_cut_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            owner_q     <= owner_d;
            out_cmd_q   <= out_cmd_d;
            out_adr_q   <= out_adr_d;
            out_data_q  <= out_data_d;
            grant_id_q  <= grant_id_d;
            burst_cut_q <= burst_cut_d;
        end
    end

    assign out_cmd   = out_cmd_q;
    assign out_adr   = out_adr_q;
    assign out_data  = out_data_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q == LOCKED);
    assign burst_cut = burst_cut_q;

endmodule

// File: tb/tb_cmd_rr_arbiter.sv
// Bench for cmd_rr_arbiter: directed scenarios followed by randomized traffic.
// Each driven cycle predicts the next registered output from a reference model;
// a monitor process compares the DUT against those predictions cycle by cycle.

module tb_cmd_rr_arbiter;

    localparam int NR = 3;
    localparam int CW = 2;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int IW = 2;

    logic               clk;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_last;
    logic [NR*CW-1:0]   req_cmd;
    logic [NR*AW-1:0]   req_adr;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic [CW-1:0]      out_cmd;
    logic [AW-1:0]      out_adr;
    logic [DW-1:0]      out_data;
    logic [IW-1:0]      grant_id;
    logic               busy;
    logic               burst_cut;

    cmd_rr_arbiter #(
        .NUM_REQ   (NR),
        .CMD_W     (CW),
        .ADR_W     (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_cmd   (req_cmd),
        .req_adr   (req_adr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_cmd   (out_cmd),
        .out_adr   (out_adr),
        .out_data  (out_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .burst_cut (burst_cut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected registered output for a given cycle.
    typedef struct {
        int          cyc;
        logic [CW-1:0] cmd;
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
        logic [IW-1:0] gid;
        logic        busy;
        logic        cut;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: who holds the port, how many beats it has used,
    // where the round-robin search starts, and the last forwarded beat.
    bit          m_locked = 0;
    int          m_owner  = 0;
    int          m_used   = 0;
    int          m_ptr    = 0;
    logic [CW-1:0] m_cmd  = '0;
    logic [AW-1:0] m_adr  = '0;
    logic [DW-1:0] m_data = '0;
    logic [IW-1:0] m_gid  = '0;

    // Called with inputs already driven (posedge + 1). Checks ready,
    // advances the model, queues the expectation for the next cycle and
    // returns one cycle later at posedge + 1.
    task automatic tick();
        logic [NR-1:0] exp_rdy;
        int            x;
        bit            cut;
        exp_t          e;
        #1;
        exp_rdy = '0;
        x       = -1;
        cut     = 0;
        if (!rst) begin
            if (m_locked) begin
                if (req_valid[m_owner]) x = m_owner;
            end else begin
                for (int k = 0; k < NR; k++) begin
                    int i;
                    i = (m_ptr + k) % NR;
                    if (x < 0 && req_valid[i]) x = i;
                end
            end
            if (x >= 0) exp_rdy[x] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));

        if (rst) begin
            m_locked = 0; m_owner = 0; m_used = 0; m_ptr = 0;
            m_cmd = '0; m_adr = '0; m_data = '0; m_gid = '0;
        end else if (x >= 0) begin
            m_cmd  = req_cmd[x*CW +: CW];
            m_adr  = req_adr[x*AW +: AW];
            m_data = req_data[x*DW +: DW];
            m_gid  = IW'(x);
            if (!m_locked) begin
                m_used = 1;
                if (req_last[x] || MB == 1) m_ptr = (x + 1) % NR;
                else begin m_locked = 1; m_owner = x; end
            end else begin
                m_used++;
                if (req_last[x] || m_used == MB) begin
                    cut      = !req_last[x];
                    m_locked = 0;
                    m_ptr    = (x + 1) % NR;
                end
            end
        end else begin
            m_cmd = '0;
        end

        e.cyc = cyc + 1; e.cmd = m_cmd; e.adr = m_adr; e.data = m_data;
        e.gid = m_gid; e.busy = m_locked; e.cut = cut;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever is due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("out_cycle", 32'(cyc), 32'(e.cyc));
                check("out_cmd",   32'(out_cmd),   32'(e.cmd));
                check("out_adr",   32'(out_adr),   32'(e.adr));
                check("out_data",  32'(out_data),  32'(e.data));
                check("grant_id",  32'(grant_id),  32'(e.gid));
                check("busy",      32'(busy),      32'(e.busy));
                check("burst_cut", 32'(burst_cut), 32'(e.cut));
            end
        end
    end

    task automatic set_req(input int i, input bit v, input bit l,
                           input logic [CW-1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_last[i]           = l;
        req_cmd[i*CW +: CW]   = c;
        req_adr[i*AW +: AW]   = a;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) set_req(i, 0, 0, '0, '0, '0);
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;

        // All three valid with single beats: strict rotation 0,1,2,...
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NR; i++) set_req(i, 1, 1, CW'(i + 1), AW'(n + i), DW'(16 * n + i));
            tick();
        end
        clear_reqs();

        // Move the pointer to 1, then a 3-beat burst from req1 while req0 waits.
        set_req(0, 1, 1, 2'd1, 4'd9, 8'h90);
        tick();
        for (int b = 0; b < 3; b++) begin
            set_req(0, 1, 1, 2'd1, 4'd9, 8'h91);
            set_req(1, 1, b == 2, 2'd2, (b == 1) ? 4'd4 : 4'd3, DW'(8'hA0 + b));
            tick();
        end
        set_req(1, 0, 0, '0, '0, '0);
        set_req(2, 1, 1, 2'd3, 4'd7, 8'hB0);
        tick();
        tick();
        clear_reqs();
        tick();

        // Long burst from req2 without last: cut after MAX_BURST beats.
        for (int b = 0; b < 10; b++) begin
            set_req(2, 1, 0, 2'd3, AW'(b), DW'(8'hC0 + b));
            if (b > 0) set_req(0, 1, 1, 2'd1, 4'd1, DW'(8'hD0 + b));
            tick();
        end
        clear_reqs();
        tick();

        // Locked owner drops valid for two cycles; req1 must keep waiting.
        set_req(0, 1, 0, 2'd1, 4'd2, 8'h10);
        tick();
        set_req(0, 0, 0, '0, '0, '0);
        set_req(1, 1, 1, 2'd2, 4'd5, 8'h20);
        tick();
        tick();
        set_req(0, 1, 1, 2'd1, 4'd3, 8'h11);
        tick();
        clear_reqs();
        tick();

        // Reset during beat 2 of a req1 burst, then req1/req2 contend.
        set_req(1, 1, 0, 2'd2, 4'd6, 8'h30);
        tick();
        set_req(1, 1, 0, 2'd2, 4'd7, 8'h31);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1, 1, 1, 2'd2, 4'd8, 8'h32);
        set_req(2, 1, 1, 2'd3, 4'd9, 8'h33);
        tick();
        tick();
        clear_reqs();

        // Quiet period after a reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) tick();

        // Randomized traffic, including cmd==0 beats and occasional reset.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NR; i++)
                set_req(i, $urandom_range(0, 99) < 60, $urandom_range(0, 2) == 0,
                        CW'($urandom), AW'($urandom), DW'($urandom));
            rst = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0;
        clear_reqs();
        tick();
        tick();

        @(posedge clk);
        #5;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
